// File: rtl/irrigation_sequencer_if.sv
// Request/grant bundle between the irrigation decision logic and the shared water-line sequencer.
interface irrigation_sequencer_if;
   logic       tick;
   logic       fault;
   logic       refill_request;
   logic       irrigation_request;
   logic       splinker_mode;
   logic       water_supply_valvule;
   logic       splinker_bomb;
   logic       dripper_valvule;
   logic       lockout;
   logic       irrigation_timeout;
   logic [2:0] state;

   modport master (
      output tick, fault, refill_request, irrigation_request, splinker_mode,
      input  water_supply_valvule, splinker_bomb, dripper_valvule, lockout,
             irrigation_timeout, state
   );

   modport slave (
      input  tick, fault, refill_request, irrigation_request, splinker_mode,
      output water_supply_valvule, splinker_bomb, dripper_valvule, lockout,
             irrigation_timeout, state
   );
endinterface

// File: rtl/irrigation_sequencer.sv
// Grants the shared water line to refill, sprinkler or dripper one at a time, with
// tick-based minimum/maximum run, an all-off dead gap between grants and a fault lockout.
module irrigation_sequencer #(
   parameter int unsigned MIN_RUN_TICKS = 4,
   parameter int unsigned MAX_RUN_TICKS = 60,
   parameter int unsigned DEAD_TICKS    = 2
) (
   input  logic                   clock,
   input  logic                   reset_n,
   irrigation_sequencer_if.slave  bus
);
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_REFILL   = 3'd1,
      ST_SPRINKLE = 3'd2,
      ST_DRIP     = 3'd3,
      ST_DEAD     = 3'd4,
      ST_LOCKOUT  = 3'd5
   } state_t;

   // A minimum above the counter's reach can never be met, so keep it out of 8-bit range.
   localparam logic [8:0] MIN_CNT   = (MIN_RUN_TICKS > 32'd255) ? 9'd256 : 9'(MIN_RUN_TICKS);
   localparam logic [7:0] MAX_LAST  = 8'(MAX_RUN_TICKS - 32'd1);
   localparam logic [7:0] DEAD_LAST = 8'(DEAD_TICKS - 32'd1);

   state_t     state_r;
   state_t     state_next_s;
   logic [7:0] run_cnt_r;
   logic [7:0] run_cnt_next_s;
   logic       timeout_r;
   logic       timeout_next_s;
   logic       max_hit_s;
   logic       min_done_s;
   logic       irr_exit_s;
   logic       refill_valve_r;
   logic       sprinkle_valve_r;
   logic       drip_valve_r;
   logic       lockout_r;

   // Next-state selection: fault first, then the per-state grant/release rules.
   always_comb begin
      state_next_s = state_r;
      max_hit_s    = 1'b0;
      min_done_s   = ({1'b0, run_cnt_r} >= MIN_CNT);
      irr_exit_s   = !bus.irrigation_request || bus.refill_request ||
                     (bus.splinker_mode != (state_r == ST_SPRINKLE));
      if (bus.fault) begin
         state_next_s = ST_LOCKOUT;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.refill_request) begin
                  state_next_s = ST_REFILL;
               end else if (bus.irrigation_request && !timeout_r) begin
                  state_next_s = bus.splinker_mode ? ST_SPRINKLE : ST_DRIP;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end
            ST_REFILL: begin
               if (!bus.refill_request && min_done_s) begin
                  state_next_s = ST_DEAD;
               end else begin
                  state_next_s = ST_REFILL;
               end
            end
            ST_SPRINKLE, ST_DRIP: begin
               if (bus.tick && (run_cnt_r == MAX_LAST)) begin
                  state_next_s = ST_DEAD;
                  max_hit_s    = 1'b1;
               end else if (min_done_s && irr_exit_s) begin
                  state_next_s = ST_DEAD;
               end else begin
                  state_next_s = state_r;
               end
            end
            ST_DEAD, ST_LOCKOUT: begin
               if (bus.tick && (run_cnt_r == DEAD_LAST)) begin
                  state_next_s = ST_IDLE;
               end else begin
                  state_next_s = state_r;
               end
            end
            default: state_next_s = ST_IDLE;
         endcase
      end
   end

   // Run counter and sticky timeout flag; a tick on a transition edge is not counted.
   always_comb begin
      run_cnt_next_s = run_cnt_r;
      timeout_next_s = timeout_r;
      if (state_next_s != state_r) begin
         run_cnt_next_s = 8'd0;
      end else if ((state_r == ST_LOCKOUT) && bus.fault) begin
         run_cnt_next_s = 8'd0;
      end else if (bus.tick && (run_cnt_r != 8'd255)) begin
         run_cnt_next_s = run_cnt_r + 8'd1;
      end else begin
         run_cnt_next_s = run_cnt_r;
      end
      if (!bus.irrigation_request) begin
         timeout_next_s = 1'b0;
      end else if (max_hit_s) begin
         timeout_next_s = 1'b1;
      end else begin
         timeout_next_s = timeout_r;
      end
   end

   // State register with outputs decoded from the next state so they move with it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r          <= ST_IDLE;
         run_cnt_r        <= 8'd0;
         timeout_r        <= 1'b0;
         refill_valve_r   <= 1'b0;
         sprinkle_valve_r <= 1'b0;
         drip_valve_r     <= 1'b0;
         lockout_r        <= 1'b0;
      end else begin
         state_r          <= state_next_s;
         run_cnt_r        <= run_cnt_next_s;
         timeout_r        <= timeout_next_s;
         refill_valve_r   <= (state_next_s == ST_REFILL);
         sprinkle_valve_r <= (state_next_s == ST_SPRINKLE);
         drip_valve_r     <= (state_next_s == ST_DRIP);
         lockout_r        <= (state_next_s == ST_LOCKOUT);
      end
   end

   assign bus.water_supply_valvule = refill_valve_r;
   assign bus.splinker_bomb        = sprinkle_valve_r;
   assign bus.dripper_valvule      = drip_valve_r;
   assign bus.lockout              = lockout_r;
   assign bus.irrigation_timeout   = timeout_r;
   assign bus.state                = state_r;
endmodule

// File: tb/tb_irrigation_sequencer.sv
// Self-checking bench: fixed vector table, hand-written corner sequences and a randomized
// run compared against a grant/phase reference model of the water-line rules.
module tb_irrigation_sequencer;
   localparam int MIN_T  = 4;
   localparam int MAX_T  = 10;
   localparam int DEAD_T = 2;

   // Packed view: {state[2:0], refill, sprinkle, drip, lockout, timeout}
   localparam logic [7:0] E_IDLE = {3'd0, 3'b000, 2'b00};
   localparam logic [7:0] E_REF  = {3'd1, 3'b100, 2'b00};
   localparam logic [7:0] E_SPR  = {3'd2, 3'b010, 2'b00};
   localparam logic [7:0] E_DRIP = {3'd3, 3'b001, 2'b00};
   localparam logic [7:0] E_DEAD = {3'd4, 3'b000, 2'b00};
   localparam logic [7:0] E_LOCK = {3'd5, 3'b000, 2'b10};

   typedef struct {
      logic       f;
      logic       r;
      logic       i;
      logic       m;
      logic       t;
      logic [7:0] exp;
   } vec_t;

   logic clock   = 1'b0;
   logic reset_n = 1'b0;
   int   n_cmp   = 0;
   int   n_err   = 0;
   int   tick_mode  = 0;
   int   tick_phase = 0;

   // Reference model: who owns the line and which phase we are in.
   int m_owner;    // 0 none, 1 refill, 2 sprinkler, 3 dripper
   int m_phase;    // 0 free, 1 granted, 2 dead gap, 3 lockout
   int m_ticks;
   bit m_timeout;

   vec_t tbl [22];

   irrigation_sequencer_if bus();

   irrigation_sequencer #(
      .MIN_RUN_TICKS (MIN_T),
      .MAX_RUN_TICKS (MAX_T),
      .DEAD_TICKS    (DEAD_T)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] outs();
      return {bus.state, bus.water_supply_valvule, bus.splinker_bomb, bus.dripper_valvule,
              bus.lockout, bus.irrigation_timeout};
   endfunction

   function automatic logic [7:0] model_outs();
      logic [2:0] code;
      logic [2:0] valves;
      code   = (m_phase == 1) ? 3'(m_owner) : (m_phase == 2) ? 3'd4 : (m_phase == 3) ? 3'd5 : 3'd0;
      valves = {m_phase == 1 && m_owner == 1, m_phase == 1 && m_owner == 2, m_phase == 1 && m_owner == 3};
      return {code, valves, m_phase == 3, m_timeout};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h required %h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_owner = 0; m_phase = 0; m_ticks = 0; m_timeout = 1'b0;
   endtask

   task automatic model_step();
      int  np = m_phase;
      int  no = m_owner;
      bit  to_set = 1'b0;
      bit  ran_min = (m_ticks >= MIN_T);
      bit  mode_ok;
      if (bus.fault) begin
         np = 3; no = 0;
      end else if (m_phase == 0) begin
         if (bus.refill_request) begin np = 1; no = 1; end
         else if (bus.irrigation_request && !m_timeout) begin np = 1; no = bus.splinker_mode ? 2 : 3; end
      end else if (m_phase == 1) begin
         if (m_owner == 1) begin
            if (!bus.refill_request && ran_min) np = 2;
         end else begin
            mode_ok = (m_owner == 2) ? bus.splinker_mode : !bus.splinker_mode;
            if (bus.tick && m_ticks + 1 == MAX_T) begin np = 2; to_set = 1'b1; end
            else if (ran_min && (!bus.irrigation_request || bus.refill_request || !mode_ok)) np = 2;
         end
         if (np == 2) no = 0;
      end else begin
         if (bus.tick && m_ticks + 1 == DEAD_T) np = 0;
      end
      if (np != m_phase || no != m_owner) m_ticks = 0;
      else if (bus.fault) m_ticks = 0;
      else if (bus.tick && m_ticks < 255) m_ticks++;
      if (!bus.irrigation_request) m_timeout = 1'b0;
      else if (to_set) m_timeout = 1'b1;
      m_phase = np;
      m_owner = no;
   endtask

   task automatic cycle();
      logic ov;
      case (tick_mode)
         0:       bus.tick = (tick_phase == 3);
         1:       bus.tick = ($urandom_range(0, 2) == 0);
         default: bus.tick = 1'b1;
      endcase
      tick_phase = (tick_phase + 1) % 4;
      model_step();
      @(posedge clock);
      #1;
      check("model", outs(), model_outs());
      ov = ($countones({bus.water_supply_valvule, bus.splinker_bomb, bus.dripper_valvule}) > 1);
      check("valve_overlap", {7'd0, ov}, 8'd0);
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      bus.tick = 1'b0; bus.fault = 1'b0; bus.refill_request = 1'b0;
      bus.irrigation_request = 1'b0; bus.splinker_mode = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      check("reset_state", outs(), E_IDLE);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      tick_phase = 0;
      tick_mode  = 0;
   endtask

   initial begin
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, E_SPR};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, E_SPR};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_SPR};
      tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_SPR};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, E_SPR};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, E_DEAD};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_DEAD};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_IDLE};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, E_REF};
      tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, E_LOCK};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_LOCK};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, E_LOCK};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, E_IDLE};
      tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, E_DRIP};
      tbl[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, E_DRIP};
      tbl[15] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, E_DRIP};
      tbl[16] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, E_DRIP};
      tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, E_DRIP};
      tbl[18] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_DEAD};
      tbl[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, E_DEAD};
      tbl[20] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, E_IDLE};
      tbl[21] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, E_REF};

      // Fixed vectors with tick supplied per row.
      do_reset();
      for (int k = 0; k < 22; k++) begin
         bus.fault              = tbl[k].f;
         bus.refill_request     = tbl[k].r;
         bus.irrigation_request = tbl[k].i;
         bus.splinker_mode      = tbl[k].m;
         bus.tick               = tbl[k].t;
         @(posedge clock);
         #1;
         check($sformatf("table_row_%0d", k), outs(), tbl[k].exp);
      end

      // Asynchronous reset in the middle of a sprinkler grant.
      do_reset();
      bus.irrigation_request = 1'b1; bus.splinker_mode = 1'b1;
      repeat (3) cycle();
      check("spr_before_reset", {7'd0, bus.splinker_bomb}, 8'd1);
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset_valve", {7'd0, bus.splinker_bomb}, 8'd0);
      check("async_reset_state", {5'd0, bus.state}, 8'd0);
      bus.irrigation_request = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      model_reset();
      repeat (3) cycle();

      // Irrigation held past the run limit, then cleared and re-granted.
      do_reset();
      bus.irrigation_request = 1'b1; bus.splinker_mode = 1'b1;
      repeat (56) cycle();
      check("timeout_set", {7'd0, bus.irrigation_timeout}, 8'd1);
      check("no_regrant", {5'd0, bus.state}, 8'd0);
      bus.irrigation_request = 1'b0;
      cycle();
      check("timeout_clear", {7'd0, bus.irrigation_timeout}, 8'd0);
      bus.irrigation_request = 1'b1;
      cycle();
      check("regrant", {5'd0, bus.state}, 8'd2);

      // Mode flip after 5 ticks of sprinkling leads to a dripper grant.
      do_reset();
      bus.irrigation_request = 1'b1; bus.splinker_mode = 1'b1;
      repeat (21) cycle();
      bus.splinker_mode = 1'b0;
      repeat (30) cycle();
      check("flip_to_drip", {7'd0, bus.dripper_valvule}, 8'd1);
      check("flip_state", {5'd0, bus.state}, 8'd3);

      // Randomized run against the reference model.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if (n % 500 == 0) tick_mode = n / 500 % 3;
         bus.fault = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 19) == 0) bus.refill_request = ~bus.refill_request;
         if ($urandom_range(0, 14) == 0) bus.irrigation_request = ~bus.irrigation_request;
         if ($urandom_range(0, 24) == 0) bus.splinker_mode = ~bus.splinker_mode;
         cycle();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
